// File: rtl/ama_riscv_fetch.sv
// Purpose: instruction fetch; issues IMEM requests and buffers returned words for decode.
// Latency: a response is visible on dec_* the cycle after it returns (1-cycle buffer).
// Backpressure: requests are credit-limited so buffered + inflight words never exceed BUF_DEPTH.
module ama_riscv_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h1_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc
);

   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);
   localparam logic [31:0]   NOP      = 32'h0000_0013;
   localparam logic [31:0]   RST_PC_A = {RESET_PC[31:2], 2'b00};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t        ibuf_mem [BUF_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] occ;
   logic [CW-1:0] inflight;
   logic [CW-1:0] stale;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   redirect_pc_a;
   logic [CW:0]   credit_use;
   logic          req_acc;
   logic          push;
   logic          pop;
   logic          unused_redirect_lsb;

   function automatic logic [PW-1:0] nxt_idx(input logic [PW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + PW'(1);
   endfunction

   assign redirect_pc_a       = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Handshakes: a response is live only when no stale responses are still owed.
   assign req_acc    = imem_req_valid && imem_req_ready;
   assign pop        = dec_valid && dec_ready;
   assign push       = !rst && !redirect && imem_rsp_valid && (stale == '0);
   // Slots already spoken for: buffered words plus outstanding requests, less the word leaving now.
   assign credit_use = {1'b0, occ} + {1'b0, inflight} - {{CW{1'b0}}, pop};

   assign imem_req_valid = !rst && !redirect && (credit_use < {1'b0, DEPTH_C});
   assign imem_req_addr  = fetch_pc;

   assign dec_valid = !rst && !redirect && (occ != '0);
   assign dec_inst  = dec_valid ? ibuf_mem[head].inst : NOP;
   assign dec_pc    = dec_valid ? ibuf_mem[head].pc   : 32'h0;

   // Fetch PC: jumps on redirect, otherwise advances by one word per accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RST_PC_A;
      end else if (redirect) begin
         fetch_pc <= redirect_pc_a;
      end else if (req_acc) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Response PC: live requests are contiguous from the last redirect, so the PC of the
   // next live response is simply tracked and bumped on each push.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_pc <= RST_PC_A;
      end else if (redirect) begin
         rsp_pc <= redirect_pc_a;
      end else if (push) begin
         rsp_pc <= rsp_pc + 32'd4;
      end
   end

   // Outstanding-request count, covering both live and stale requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         inflight <= inflight + CW'(req_acc) - CW'(imem_rsp_valid);
      end
   end

   // Stale count: on redirect every outstanding request (less one returning now) becomes stale;
   // each later response is dropped until the count drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         stale <= '0;
      end else if (redirect) begin
         stale <= inflight - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (stale != '0)) begin
         stale <= stale - CW'(1);
      end
   end

   // Buffer pointers and occupancy; redirect flushes everything buffered.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) begin
            tail <= nxt_idx(tail);
         end
         if (pop) begin
            head <= nxt_idx(head);
         end
         occ <= occ + CW'(push) - CW'(pop);
      end
   end

   // Buffer storage written at the tail on each live response.
   always_ff @(posedge clk) begin
      if (push) begin
         ibuf_mem[tail] <= '{pc: rsp_pc, inst: imem_rsp_data};
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (occ == DEPTH_C)));

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (inflight == '0)));

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Bench for ama_riscv_fetch: vector table, directed corner sequences, randomized run.
// IMEM is modelled in order with per-request latency; a queue-based reference predicts outputs.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_ama_riscv_fetch;

   localparam logic [31:0] RST_PC = 32'h0001_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;

   ama_riscv_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          drdy;
      bit          rv;
      logic [31:0] addr;
      bit          dv;
      logic [31:0] pc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } ireq_t;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ment_t;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int last_due = 0;
   int lat_min  = 1;
   int lat_max  = 1;

   bit          i_rst   = 1'b1;
   bit          i_redir = 1'b0;
   logic [31:0] i_rpc   = 32'h0;
   bit          i_rdy   = 1'b1;
   bit          i_drdy  = 1'b1;

   bit          o_rv;
   logic [31:0] o_addr;
   bit          o_dv;
   logic [31:0] o_pc;
   logic [31:0] o_inst;

   ireq_t       imem_q [$];
   ment_t       m_buf  [$];
   mreq_t       m_infl [$];
   logic [31:0] m_fpc = RST_PC;

   vec_t vt [15];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[29:0], 2'b11} ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
   endtask

   // One clock: drive inputs and the IMEM response, sample outputs, check and advance the model.
   task automatic cycle();
      bit          e_dv;
      bit          e_rv;
      bit          m_pop;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      mreq_t       r;
      int          due;
      @(posedge clk);
      #1;
      cyc++;
      rst            = i_rst;
      redirect       = i_redir;
      redirect_pc    = i_rpc;
      imem_req_ready = i_rdy;
      dec_ready      = i_drdy;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (i_rst) begin
         imem_q.delete();
         last_due = cyc;
      end else if (imem_q.size() != 0 && imem_q[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = inst_of(imem_q[0].addr);
         void'(imem_q.pop_front());
      end
      @(negedge clk);
      o_rv   = imem_req_valid;
      o_addr = imem_req_addr;
      o_dv   = dec_valid;
      o_pc   = dec_pc;
      o_inst = dec_inst;

      if (i_rst) begin
         chk("model_rst_req_valid", 32'(o_rv), 32'h0);
         chk("model_rst_dec_valid", 32'(o_dv), 32'h0);
         chk("model_rst_dec_inst", o_inst, NOP);
         chk("model_rst_dec_pc", o_pc, 32'h0);
         m_buf.delete();
         m_infl.delete();
         m_fpc = RST_PC;
      end else begin
         e_dv   = (m_buf.size() != 0) && !i_redir;
         e_pc   = e_dv ? m_buf[0].pc : 32'h0;
         e_inst = e_dv ? m_buf[0].inst : NOP;
         m_pop  = e_dv && i_drdy;
         e_rv   = !i_redir && ((m_buf.size() + m_infl.size() - int'(m_pop)) < DEPTH);
         chk("model_req_valid", 32'(o_rv), 32'(e_rv));
         if (e_rv) chk("model_req_addr", o_addr, m_fpc);
         chk("model_dec_valid", 32'(o_dv), 32'(e_dv));
         chk("model_dec_pc", o_pc, e_pc);
         chk("model_dec_inst", o_inst, e_inst);
         if (m_pop) void'(m_buf.pop_front());
         if (imem_rsp_valid) begin
            if (m_infl.size() == 0) begin
               fail_now("model_rsp_without_request");
            end else begin
               r = m_infl.pop_front();
               if (!r.stale && !i_redir) m_buf.push_back('{pc: r.pc, inst: imem_rsp_data});
            end
         end
         if (i_redir) begin
            m_buf.delete();
            for (int k = 0; k < m_infl.size(); k++) begin
               r = m_infl[k];
               r.stale = 1'b1;
               m_infl[k] = r;
            end
            m_fpc = {i_rpc[31:2], 2'b00};
         end else if (e_rv && i_rdy) begin
            m_infl.push_back('{pc: m_fpc, stale: 1'b0});
            m_fpc = m_fpc + 32'd4;
         end
      end

      if (!i_rst && o_rv && i_rdy) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         imem_q.push_back('{addr: o_addr, due: due});
         last_due = due;
      end
   endtask

   task automatic reset_dut();
      i_rst   = 1'b1;
      i_redir = 1'b0;
      repeat (2) cycle();
      i_rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit got_req;
      bit got_dec;
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; dec_ready = 1'b1;

      // rst, dec_ready -> req_valid, req_addr, dec_valid, dec_pc (IMEM latency 1, always ready)
      vt[0]  = '{1, 1, 0, 32'h0,         0, 32'h0};
      vt[1]  = '{1, 1, 0, 32'h0,         0, 32'h0};
      vt[2]  = '{0, 1, 1, 32'h0001_0000, 0, 32'h0};
      vt[3]  = '{0, 1, 1, 32'h0001_0004, 0, 32'h0};
      vt[4]  = '{0, 1, 1, 32'h0001_0008, 1, 32'h0001_0000};
      vt[5]  = '{0, 1, 1, 32'h0001_000C, 1, 32'h0001_0004};
      vt[6]  = '{1, 1, 0, 32'h0,         0, 32'h0};
      vt[7]  = '{1, 0, 0, 32'h0,         0, 32'h0};
      vt[8]  = '{0, 0, 1, 32'h0001_0000, 0, 32'h0};
      vt[9]  = '{0, 0, 1, 32'h0001_0004, 0, 32'h0};
      vt[10] = '{0, 0, 0, 32'h0,         1, 32'h0001_0000};
      vt[11] = '{0, 0, 0, 32'h0,         1, 32'h0001_0000};
      vt[12] = '{0, 1, 1, 32'h0001_0008, 1, 32'h0001_0000};
      vt[13] = '{0, 1, 1, 32'h0001_000C, 1, 32'h0001_0004};
      vt[14] = '{0, 1, 1, 32'h0001_0010, 1, 32'h0001_0008};

      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 15; i++) begin
         i_rst = vt[i].rst; i_drdy = vt[i].drdy; i_rdy = 1'b1; i_redir = 1'b0;
         cycle();
         chk($sformatf("vec%0d_req_valid", i), 32'(o_rv), 32'(vt[i].rv));
         if (vt[i].rv) chk($sformatf("vec%0d_req_addr", i), o_addr, vt[i].addr);
         chk($sformatf("vec%0d_dec_valid", i), 32'(o_dv), 32'(vt[i].dv));
         chk($sformatf("vec%0d_dec_pc", i), o_pc, vt[i].pc);
         chk($sformatf("vec%0d_dec_inst", i), o_inst, vt[i].dv ? inst_of(vt[i].pc) : NOP);
      end

      // IMEM stall: address must hold while the request waits.
      reset_dut();
      i_rdy = 1'b1; i_drdy = 1'b1;
      cycle();
      chk("stall_first_addr", o_addr, 32'h0001_0000);
      i_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("stall_req_valid", 32'(o_rv), 32'h1);
         chk("stall_req_addr", o_addr, 32'h0001_0004);
      end
      i_rdy = 1'b1;
      cycle();
      chk("stall_release_addr", o_addr, 32'h0001_0004);
      cycle();
      chk("stall_advance_addr", o_addr, 32'h0001_0008);

      // Redirect with two requests in flight at latency 3.
      lat_min = 3; lat_max = 3;
      reset_dut();
      i_rdy = 1'b1; i_drdy = 1'b1;
      cycle();
      cycle();
      cycle();
      chk("redir_credit_exhausted", 32'(o_rv), 32'h0);
      i_redir = 1'b1; i_rpc = 32'h0001_0100;
      cycle();
      chk("redir_no_req", 32'(o_rv), 32'h0);
      chk("redir_no_dec", 32'(o_dv), 32'h0);
      i_redir = 1'b0;
      got_req = 1'b0; got_dec = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (!got_dec) begin
            cycle();
            if (!got_req && o_rv) begin
               got_req = 1'b1;
               chk("redir_first_req_addr", o_addr, 32'h0001_0100);
            end
            if (o_dv) begin
               got_dec = 1'b1;
               chk("redir_first_dec_pc", o_pc, 32'h0001_0100);
               chk("redir_first_dec_inst", o_inst, inst_of(32'h0001_0100));
            end
         end
      end
      if (!got_req) fail_now("redir_req_timeout");
      if (!got_dec) fail_now("redir_dec_timeout");

      // Misaligned redirect target is word-aligned.
      i_redir = 1'b1; i_rpc = 32'h0001_0102;
      cycle();
      i_redir = 1'b0;
      cycle();
      chk("redir_align_addr", o_addr, 32'h0001_0100);

      // Back-to-back redirects then PC wrap at the top of the address space.
      i_redir = 1'b1; i_rpc = 32'h0000_4000;
      cycle();
      i_rpc = 32'hFFFF_FFFC;
      cycle();
      i_redir = 1'b0;
      got_req = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!got_req) begin
            cycle();
            if (o_rv) begin
               got_req = 1'b1;
               chk("wrap_last_addr", o_addr, 32'hFFFF_FFFC);
            end
         end
      end
      if (!got_req) fail_now("wrap_req_timeout");
      cycle();
      chk("wrap_zero_addr", o_addr, 32'h0);

      // Reset with the buffer full: everything is discarded and fetch restarts.
      lat_min = 1; lat_max = 1;
      reset_dut();
      i_drdy = 1'b0; i_rdy = 1'b1;
      repeat (4) cycle();
      chk("rstmid_buffered_valid", 32'(o_dv), 32'h1);
      chk("rstmid_buffered_pc", o_pc, 32'h0001_0000);
      i_rst = 1'b1;
      cycle();
      chk("rstmid_dec_valid_in_rst", 32'(o_dv), 32'h0);
      i_rst = 1'b0;
      cycle();
      chk("rstmid_dec_valid_after", 32'(o_dv), 32'h0);
      chk("rstmid_req_valid_after", 32'(o_rv), 32'h1);
      chk("rstmid_req_addr_after", o_addr, 32'h0001_0000);

      // Randomized traffic against the reference model.
      lat_min = 1; lat_max = 4;
      for (int k = 0; k < 4000; k++) begin
         i_rst   = ($urandom_range(199, 0) == 0);
         i_redir = !i_rst && ($urandom_range(19, 0) == 0);
         if ($urandom_range(3, 0) == 0) i_rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
         else                           i_rpc = $urandom();
         i_rdy  = ($urandom_range(3, 0) != 0);
         i_drdy = ($urandom_range(2, 0) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
